// File: rtl/fsk_mod_pkg.sv
// Shared types and helpers for the FSK modulator NCO: mode encoding,
// noise LFSR constants and the output saturation function.
package fsk_mod_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'd0,
        MODE_CW        = 2'd1,
        MODE_FSK       = 2'd2,
        MODE_FSK_BURST = 2'd3
    } mode_e;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic int sat(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fsk_sin_lut.sv
// Quarter-wave sine magnitude ROM, contents built at elaboration,
// with a single registered read port.
module fsk_sin_lut #(
    parameter int AW    = 8,
    parameter int MAG_W = 11
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr,
    output logic [MAG_W-1:0] mag
);
    localparam int  DEPTH   = 1 << AW;
    localparam real PI_HALF = 1.5707963267948966;

    // Entries sit at half-step offsets so the mirrored quadrants reuse them exactly
    function automatic logic [DEPTH*MAG_W-1:0] build_rom();
        logic [DEPTH*MAG_W-1:0] rom;
        real amp;
        real x;
        rom = '0;
        amp = real'((1 << MAG_W) - 1);
        for (int i = 0; i < DEPTH; i++) begin
            x = amp * $sin(PI_HALF * (real'(i) + 0.5) / real'(DEPTH));
            rom[i*MAG_W +: MAG_W] = MAG_W'($rtoi(x + 0.5));
        end
        return rom;
    endfunction

    localparam logic [DEPTH*MAG_W-1:0] ROM = build_rom();

    // NOTE: the read register has no reset; it maps onto ROM/BRAM output
    // registers, and the pipeline valid bits decide when its value matters.
    always_ff @(posedge clk) begin
        mag <= ROM[int'(addr)*MAG_W +: MAG_W];
    end

endmodule

// File: rtl/fsk_mod_nco.sv
// FSK modulator: symbol-scaled frequency word drives a phase accumulator,
// quarter-wave LUT gives the sine, LFSR noise is added with saturation.
module fsk_mod_nco
    import fsk_mod_pkg::*;
#(
    parameter int IN_W    = 9,
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 12,   // noise taps lfsr[OUT_W-1:0], so OUT_W <= 16
    parameter int DIV     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PHASE_W-1:0]        fc_word,
    input  logic [PHASE_W-1:0]        fdev_word,
    input  logic [3:0]                noise_shift,
    input  logic [1:0]                mode,
    input  logic signed [IN_W-1:0]    gf_in,
    input  logic                      gf_valid,
    output logic                      gf_ready,
    output logic signed [OUT_W-1:0]   sig_out,
    output logic                      sig_valid,
    output logic                      underrun
);
    localparam int IDX_W  = LUT_AW + 2;
    localparam int MAG_W  = OUT_W - 1;
    localparam int PROD_W = PHASE_W + IN_W;
    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    mode_e mode_cur;
    assign mode_cur = mode_e'(mode);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick     = (div_cnt == DIV_LAST);
    assign gf_ready = tick;

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + DIV_W'(1);
    end

    logic signed [IN_W-1:0]   gf_q;
    logic signed [PROD_W-1:0] fdev_ext;
    logic signed [PROD_W-1:0] gf_ext;
    logic signed [PROD_W-1:0] dev_prod;
    logic [PHASE_W-1:0]       dev_word;
    logic [PHASE_W-1:0]       f_word;
    logic [PHASE_W-1:0]       phase;
    logic                     unused_prod;

    assign fdev_ext    = {{IN_W{fdev_word[PHASE_W-1]}}, fdev_word};
    assign gf_ext      = {{PHASE_W{gf_q[IN_W-1]}}, gf_q};
    assign dev_prod    = fdev_ext * gf_ext;
    // Arithmetic >>> (IN_W-1) then truncation to PHASE_W is just a bit slice
    assign dev_word    = dev_prod[IN_W-1 +: PHASE_W];
    assign unused_prod = ^{dev_prod[PROD_W-1], dev_prod[IN_W-2:0]};

    // NOTE: combinational outputs get a default before the case so no path
    // leaves them unassigned and no latch is inferred.
    always_comb begin
        f_word = '0;
        case (mode_cur)
            MODE_CW:                  f_word = fc_word;
            MODE_FSK, MODE_FSK_BURST: f_word = fc_word + dev_word;
            default:                  f_word = '0;
        endcase
    end

    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            gf_q     <= '0;
            underrun <= 1'b0;
            lfsr     <= LFSR_SEED;
        end else if (tick) begin
            phase <= phase + f_word;
            lfsr  <= lfsr_step(lfsr);
            if (gf_valid) begin
                gf_q <= gf_in;
            end else if (mode_cur == MODE_FSK) begin
                underrun <= 1'b1;
            end else if (mode_cur == MODE_FSK_BURST) begin
                gf_q     <= '0;
                underrun <= 1'b1;
            end
        end
    end

    logic                    blank_now;
    logic signed [OUT_W-1:0] lfsr_s;
    logic signed [OUT_W-1:0] noise;

    assign blank_now = (mode_cur == MODE_OFF) ||
                       (mode_cur == MODE_FSK_BURST && !gf_valid);
    assign lfsr_s    = lfsr[OUT_W-1:0];

    // Kept out of a ?: with '0 so the shift stays signed (arithmetic)
    always_comb begin
        noise = '0;
        if (int'(noise_shift) < OUT_W) noise = lfsr_s >>> noise_shift;
    end

    logic                    s1_valid;
    logic [IDX_W-1:0]        s1_idx;
    logic                    s1_blank;
    logic signed [OUT_W-1:0] s1_noise;
    logic [1:0]              s1_quad;
    logic [LUT_AW-1:0]       lut_addr;
    logic [MAG_W-1:0]        lut_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_blank <= 1'b0;
            s1_noise <= '0;
        end else begin
            s1_valid <= tick;
            if (tick) begin
                s1_idx   <= phase[PHASE_W-1 -: IDX_W];
                s1_blank <= blank_now;
                s1_noise <= noise;
            end
        end
    end

    // Quadrants 1 and 3 run the table backwards; 2 and 3 are negated
    assign s1_quad  = s1_idx[IDX_W-1 -: 2];
    assign lut_addr = s1_quad[0] ? ~s1_idx[LUT_AW-1:0] : s1_idx[LUT_AW-1:0];

    fsk_sin_lut #(
        .AW    (LUT_AW),
        .MAG_W (MAG_W)
    ) u_lut (
        .clk  (clk),
        .addr (lut_addr),
        .mag  (lut_mag)
    );

    logic                    s2_valid;
    logic                    s2_neg;
    logic                    s2_blank;
    logic signed [OUT_W-1:0] s2_noise;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_neg   <= 1'b0;
            s2_blank <= 1'b0;
            s2_noise <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_neg   <= s1_quad[1];
            s2_blank <= s1_blank;
            s2_noise <= s1_noise;
        end
    end

    logic signed [OUT_W-1:0] sine;
    logic signed [OUT_W:0]   sum;
    logic signed [OUT_W-1:0] sig_next;

    always_comb begin
        sine = '0;
        if (!s2_blank) sine = s2_neg ? -$signed({1'b0, lut_mag}) : $signed({1'b0, lut_mag});
        sum      = {sine[OUT_W-1], sine} + {s2_noise[OUT_W-1], s2_noise};
        sig_next = OUT_W'(sat(int'(sum), OUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_out   <= '0;
            sig_valid <= 1'b0;
        end else begin
            sig_valid <= s2_valid;
            if (s2_valid) sig_out <= sig_next;
        end
    end

endmodule

// File: tb/tb_fsk_mod_nco.sv
// Directed bench for fsk_mod_nco: CW, FSK, extreme deviation, burst blanking,
// saturation with full noise, and a DIV=4 instance with mid-stream reset.
module tb_fsk_mod_nco;
    import fsk_mod_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [23:0]        fc_word = '0;
    logic [23:0]        fdev_word = '0;
    logic [3:0]         noise_shift = 4'd15;
    logic [1:0]         mode = MODE_OFF;
    logic signed [8:0]  gf_in = '0;
    logic               gf_valid = 1'b0;

    logic               gf_ready, sig_valid, underrun;
    logic signed [11:0] sig_out;
    logic               gf_ready4, sig_valid4, underrun4;
    logic signed [11:0] sig_out4;

    int compared   = 0;
    int mismatched = 0;

    int unsigned m_ph;
    int          m_gq;
    logic [15:0] m_lf;
    int          got[$];
    int          expq[$];

    fsk_mod_nco dut (
        .clk(clk), .rst(rst), .fc_word(fc_word), .fdev_word(fdev_word),
        .noise_shift(noise_shift), .mode(mode), .gf_in(gf_in), .gf_valid(gf_valid),
        .gf_ready(gf_ready), .sig_out(sig_out), .sig_valid(sig_valid), .underrun(underrun)
    );

    fsk_mod_nco #(.DIV(4)) dut4 (
        .clk(clk), .rst(rst), .fc_word(fc_word), .fdev_word(fdev_word),
        .noise_shift(noise_shift), .mode(mode), .gf_in(gf_in), .gf_valid(gf_valid),
        .gf_ready(gf_ready4), .sig_out(sig_out4), .sig_valid(sig_valid4), .underrun(underrun4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sig_valid) got.push_back(int'(sig_out));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
        $fatal(1);
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] lf);
        return lf[0] ? ((lf >> 1) ^ 16'hB400) : (lf >> 1);
    endfunction

    // Full-wave reference on the top 10 phase bits, noise and clamp applied
    function automatic int exp_sample(input int unsigned ph, input logic [15:0] lf,
                                      input int ns, input bit blank);
        real v;
        int s, n, t;
        int unsigned p;
        logic signed [11:0] l12;
        p = (ph >> 14) & 1023;
        v = 2047.0 * $sin(2.0 * 3.14159265358979 * (real'(p) + 0.5) / 1024.0);
        if (v >= 0.0) s = $rtoi(v + 0.5);
        else          s = -$rtoi(-v + 0.5);
        if (blank) s = 0;
        l12 = lf[11:0];
        n = (ns >= 12) ? 0 : (int'(l12) >>> ns);
        t = s + n;
        if (t > 2047)  t = 2047;
        if (t < -2048) t = -2048;
        return t;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got.delete();
        expq.delete();
        m_ph = 0;
        m_gq = 0;
        m_lf = 16'hACE1;
        rst  = 1'b0;
    endtask

    // Drives one DIV=1 tick and advances the reference model alongside it
    task automatic drive_tick(input logic [1:0] md, input int gf, input bit gfv);
        bit          blank;
        longint      dev;
        int unsigned f;
        mode     = md;
        gf_in    = 9'(gf);
        gf_valid = gfv;
        blank = (md == MODE_OFF) || (md == MODE_FSK_BURST && !gfv);
        expq.push_back(exp_sample(m_ph, m_lf, int'(noise_shift), blank));
        dev = (longint'($signed(fdev_word)) * longint'(m_gq)) >>> 8;
        case (md)
            MODE_OFF: f = 0;
            MODE_CW:  f = int'(fc_word);
            default:  f = int'((longint'(fc_word) + dev) & 64'hFF_FFFF);
        endcase
        m_ph = (m_ph + f) & 32'hFF_FFFF;
        if (gfv)                          m_gq = gf;
        else if (md == MODE_FSK_BURST)    m_gq = 0;
        m_lf = lfsr_next(m_lf);
        @(negedge clk);
    endtask

    task automatic wait_samples(input int n, input string name);
        for (int c = 0; c < n + 20 && got.size() < n; c++) @(negedge clk);
        compared++;
        if (got.size() < n) begin
            mismatched++;
            $display("FAIL %s timeout: %0d samples seen, %0d required", name, got.size(), n);
        end
    endtask

    task automatic test_reset();
        mode = MODE_CW; fc_word = 24'h10_0000; fdev_word = '0; noise_shift = 4'd15;
        gf_valid = 1'b1; gf_in = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared += 5;
        if (sig_valid !== 1'b0)   begin mismatched++; $display("FAIL reset sig_valid: got %b want 0", sig_valid); end
        if (sig_out !== 12'sd0)   begin mismatched++; $display("FAIL reset sig_out: got %0d want 0", sig_out); end
        if (underrun !== 1'b0)    begin mismatched++; $display("FAIL reset underrun: got %b want 0", underrun); end
        if (sig_valid4 !== 1'b0)  begin mismatched++; $display("FAIL reset sig_valid4: got %b want 0", sig_valid4); end
        if (sig_out4 !== 12'sd0)  begin mismatched++; $display("FAIL reset sig_out4: got %0d want 0", sig_out4); end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            compared += 2;
            if (sig_valid !== (c == 3)) begin
                mismatched++;
                $display("FAIL latency cycle %0d sig_valid: got %b want %b", c, sig_valid, (c == 3));
            end
            if (gf_ready !== 1'b1) begin
                mismatched++;
                $display("FAIL div1 gf_ready cycle %0d: got %b want 1", c, gf_ready);
            end
        end
    endtask

    task automatic test_cw();
        int mx, mn;
        mode = MODE_CW; fc_word = 24'h10_0000; fdev_word = '0; noise_shift = 4'd15;
        apply_reset();
        for (int k = 0; k < 32; k++) drive_tick(MODE_CW, 0, 1'b1);
        wait_samples(32, "cw");
        mx = -9999; mn = 9999;
        for (int k = 0; k < 32 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== expq[k]) begin
                mismatched++;
                $display("FAIL cw sample %0d: got %0d want %0d", k, got[k], expq[k]);
            end
            if (got[k] > mx) mx = got[k];
            if (got[k] < mn) mn = got[k];
        end
        compared += 2;
        if (mx !== 2047)  begin mismatched++; $display("FAIL cw peak: got %0d want 2047", mx); end
        if (mn !== -2047) begin mismatched++; $display("FAIL cw trough: got %0d want -2047", mn); end
    endtask

    task automatic test_fsk();
        mode = MODE_FSK; fc_word = 24'h10_0000; fdev_word = 24'h08_0000; noise_shift = 4'd15;
        apply_reset();
        for (int k = 0; k < 24; k++) drive_tick(MODE_FSK, 255, 1'b1);
        for (int k = 24; k < 60; k++) drive_tick(MODE_FSK, -256, 1'b1);
        compared++;
        if (underrun !== 1'b0) begin mismatched++; $display("FAIL fsk underrun early: got %b want 0", underrun); end
        for (int k = 60; k < 64; k++) drive_tick(MODE_FSK, 100, 1'b0);
        for (int k = 64; k < 70; k++) drive_tick(MODE_FSK, -256, 1'b1);
        wait_samples(70, "fsk");
        for (int k = 0; k < 70 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== expq[k]) begin
                mismatched++;
                $display("FAIL fsk sample %0d: got %0d want %0d", k, got[k], expq[k]);
            end
        end
        compared++;
        if (underrun !== 1'b1) begin mismatched++; $display("FAIL fsk underrun sticky: got %b want 1", underrun); end
    endtask

    task automatic test_extreme();
        mode = MODE_OFF; fc_word = 24'h10_0000; fdev_word = 24'h10_0000; noise_shift = 4'd15;
        gf_in = -9'sd256; gf_valid = 1'b1;
        apply_reset();
        drive_tick(MODE_OFF, -256, 1'b1);
        for (int k = 1; k < 16; k++) drive_tick(MODE_FSK, -256, 1'b1);
        wait_samples(16, "extreme");
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== expq[k]) begin
                mismatched++;
                $display("FAIL extreme sample %0d: got %0d want %0d", k, got[k], expq[k]);
            end
        end
        if (got.size() >= 16) begin
            compared += 3;
            if (got[0] !== 0)  begin mismatched++; $display("FAIL off blank: got %0d want 0", got[0]); end
            if (got[1] !== 6)  begin mismatched++; $display("FAIL f0 idx0 first: got %0d want 6", got[1]); end
            if (got[15] !== 6) begin mismatched++; $display("FAIL f0 idx0 last: got %0d want 6", got[15]); end
        end
    endtask

    task automatic test_burst();
        bit v;
        mode = MODE_FSK_BURST; fc_word = 24'h10_0000; fdev_word = '0; noise_shift = 4'd15;
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            v = !(k >= 10 && k < 15);
            drive_tick(MODE_FSK_BURST, 7, v);
            compared++;
            if (underrun !== (k >= 10)) begin
                mismatched++;
                $display("FAIL burst underrun tick %0d: got %b want %b", k, underrun, (k >= 10));
            end
        end
        wait_samples(25, "burst");
        for (int k = 0; k < 25 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== expq[k]) begin
                mismatched++;
                $display("FAIL burst sample %0d: got %0d want %0d", k, got[k], expq[k]);
            end
        end
    endtask

    task automatic test_saturation();
        mode = MODE_CW; fc_word = 24'h10_0000; fdev_word = '0; noise_shift = 4'd0;
        apply_reset();
        for (int k = 0; k < 48; k++) drive_tick(MODE_CW, 0, 1'b1);
        wait_samples(48, "sat");
        for (int k = 0; k < 48 && k < got.size(); k++) begin
            compared++;
            if (got[k] !== expq[k]) begin
                mismatched++;
                $display("FAIL sat sample %0d: got %0d want %0d", k, got[k], expq[k]);
            end
        end
        if (got.size() > 0) begin
            compared++;
            if (got[0] !== -793) begin mismatched++; $display("FAIL sat first: got %0d want -793", got[0]); end
        end
    endtask

    task automatic test_div4_reset();
        logic [15:0] lf;
        int          k, e;
        bit          exp_v;
        mode = MODE_CW; fc_word = 24'h10_0000; fdev_word = '0; noise_shift = 4'd4;
        gf_valid = 1'b1; gf_in = '0;
        apply_reset();
        for (int pass = 0; pass < 2; pass++) begin
            lf = 16'hACE1;
            k  = 0;
            for (int j = 1; j <= 36; j++) begin
                @(negedge clk);
                exp_v = (j >= 6) && (j % 4 == 2);
                compared += 2;
                if (gf_ready4 !== (j % 4 == 3)) begin
                    mismatched++;
                    $display("FAIL div4 gf_ready pass %0d cyc %0d: got %b want %b", pass, j, gf_ready4, (j % 4 == 3));
                end
                if (sig_valid4 !== exp_v) begin
                    mismatched++;
                    $display("FAIL div4 sig_valid pass %0d cyc %0d: got %b want %b", pass, j, sig_valid4, exp_v);
                end
                if (exp_v) begin
                    e = exp_sample((k * 32'h10_0000) & 32'hFF_FFFF, lf, 4, 1'b0);
                    compared++;
                    if (int'(sig_out4) !== e) begin
                        mismatched++;
                        $display("FAIL div4 sample pass %0d k %0d: got %0d want %0d", pass, k, sig_out4, e);
                    end
                    if (k == 0) begin
                        compared++;
                        if (sig_out4 !== -12'sd44) begin
                            mismatched++;
                            $display("FAIL div4 first pass %0d: got %0d want -44", pass, sig_out4);
                        end
                    end
                    lf = lfsr_next(lf);
                    k++;
                end
            end
            rst = 1'b1;
            @(negedge clk);
            compared += 3;
            if (sig_valid4 !== 1'b0) begin mismatched++; $display("FAIL div4 flush valid pass %0d: got %b want 0", pass, sig_valid4); end
            if (sig_out4 !== 12'sd0) begin mismatched++; $display("FAIL div4 flush out pass %0d: got %0d want 0", pass, sig_out4); end
            if (underrun4 !== 1'b0)  begin mismatched++; $display("FAIL div4 underrun pass %0d: got %b want 0", pass, underrun4); end
            rst = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_cw();
        test_fsk();
        test_extreme();
        test_burst();
        test_saturation();
        test_div4_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
